alu_issue_stage: RTL and testbench

Request buffer and result-capture stage that sits directly upstream of the combinational 32-bit ALU and closes the loop on its outputs. It queues {operandA, operandB, command, tag} requests under a valid/ready handshake and presents the queue head to the ALU. It holds the head stable for a programmable settle window to cover gate-level ALU delay. It then captures result, carryout, overflow and a locally computed zero flag into a registered output with its own valid/ready handshake.

---
 rtl/alu_issue_stage.sv | 102 ++++++++++
 tb/tb_alu_issue_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: request FIFO feeding a combinational ALU, with settle-window hold and registered result capture.
module alu_issue_stage #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [2:0]                 in_cmd,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [31:0]                alu_operandA,
  output logic [31:0]                alu_operandB,
  output logic [2:0]                 alu_command,
  input  logic [31:0]                alu_result,
  input  logic                       alu_carryout,
  input  logic                       alu_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic                       out_carryout,
  output logic                       out_zero,
  output logic                       out_overflow,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(SETTLE + 1);
  logic [31:0]      a_q [DEPTH];
  logic [31:0]      b_q [DEPTH];
  logic [2:0]       c_q [DEPTH];
  logic [TAG_W-1:0] t_q [DEPTH];
  logic [AW-1:0]    rd, wr;
  logic [SW-1:0]    cnt;
  logic [CW-1:0]    nxt_count;
  logic             busy, push, cap, load, arith;
  assign busy         = count != '0;
  assign in_ready     = !flush && (count < CW'(DEPTH));
  assign push         = in_valid && in_ready;
  assign cap          = !flush && busy && cnt == '0 && (!out_valid || out_ready);
  assign nxt_count    = count + CW'(push) - CW'(cap);
  // a fresh head restarts the settle window so the ALU output has time to resolve
  assign load         = (push && !busy) || (cap && nxt_count != '0);
  assign alu_operandA = busy ? a_q[rd] : '0;
  assign alu_operandB = busy ? b_q[rd] : '0;
  assign alu_command  = busy ? c_q[rd] : '0;
  assign arith        = alu_command <= 3'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rd    <= '0;
      wr    <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else if (flush) begin
      count <= '0;
      rd    <= '0;
      wr    <= '0;
      cnt   <= '0;
    end else begin
      if (push) begin
        a_q[wr] <= in_a;
        b_q[wr] <= in_b;
        c_q[wr] <= in_cmd;
        t_q[wr] <= in_tag;
        wr      <= wr + 1'b1;
      end
      if (cap) rd <= rd + 1'b1;
      count <= nxt_count;
      cnt   <= load ? SW'(SETTLE) : cnt != '0 ? cnt - SW'(1) : cnt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_carryout <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_tag      <= '0;
    end else if (cap) begin
      out_valid    <= 1'b1;
      out_result   <= alu_result;
      out_carryout <= arith && alu_carryout;
      out_zero     <= alu_result == '0;
      out_overflow <= arith && alu_overflow;
      out_tag      <= t_q[rd];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of queueing, settle timing, capture, flush and async reset.
module tb_alu_issue_stage;
  localparam int TAG_W = 4;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, alu_operandA, alu_operandB, alu_result, out_result;
  logic [2:0]  in_cmd, alu_command;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic        alu_carryout, alu_overflow, out_carryout, out_zero, out_overflow;
  logic [2:0]  count;
  int          errors = 0, checks = 0, cyc = 0;
  alu_issue_stage #(.DEPTH(4), .TAG_W(TAG_W), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd), .in_tag(in_tag),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
    .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carryout(out_carryout), .out_zero(out_zero), .out_overflow(out_overflow),
    .out_tag(out_tag), .count(count)
  );
  always #5 clk = ~clk;
  // stand-in ALU; logic ops drive carry/overflow high to prove the stage masks them
  always_comb begin
    logic [32:0] s;
    s            = '0;
    alu_result   = '0;
    alu_carryout = 1'b1;
    alu_overflow = 1'b1;
    case (alu_command)
      3'd0: begin
        s            = {1'b0, alu_operandA} + {1'b0, alu_operandB};
        alu_result   = s[31:0];
        alu_carryout = s[32];
        alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (s[31] != alu_operandA[31]);
      end
      3'd1: begin
        s            = {1'b0, alu_operandA} + {1'b0, ~alu_operandB} + 33'd1;
        alu_result   = s[31:0];
        alu_carryout = s[32];
        alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (s[31] != alu_operandA[31]);
      end
      3'd2: alu_result = alu_operandA ^ alu_operandB;
      3'd3: alu_result = {31'd0, $signed(alu_operandA) < $signed(alu_operandB)};
      3'd4: alu_result = alu_operandA & alu_operandB;
      3'd5: alu_result = ~(alu_operandA & alu_operandB);
      3'd6: alu_result = ~(alu_operandA | alu_operandB);
      default: alu_result = alu_operandA | alu_operandB;
    endcase
  end
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c, input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cmd   = c;
    in_tag   = t;
    tick();
    in_valid = 1'b0;
  endtask
  initial begin
    int got, extra, t0, t1, t2, seen;
    logic [31:0] ahist [32];
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cmd = '0; in_tag = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_alu_a", alu_operandA, 0);
    chk("idle_alu_b", alu_operandB, 0);
    chk("idle_alu_cmd", alu_command, 0);
    tick();
    // ADD overflow, latency SETTLE+1
    push(32'h7FFF_FFFF, 32'h1, 3'd0, 4'd3);
    chk("add_count", count, 1);
    chk("add_alu_a", alu_operandA, 32'h7FFF_FFFF);
    tick();
    chk("add_lat1", out_valid, 0);
    tick();
    chk("add_lat2", out_valid, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 32'h8000_0000);
    chk("add_ovf", out_overflow, 1);
    chk("add_carry", out_carryout, 0);
    chk("add_zero", out_zero, 0);
    chk("add_tag", out_tag, 3);
    tick();
    chk("add_handshake", out_valid, 0);
    // SUB 5-5 then XOR masking
    push(32'd5, 32'd5, 3'd1, 4'd1);
    repeat (3) tick();
    chk("sub_valid", out_valid, 1);
    chk("sub_result", out_result, 0);
    chk("sub_zero", out_zero, 1);
    chk("sub_carry", out_carryout, 1);
    chk("sub_ovf", out_overflow, 0);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 4'd2);
    repeat (3) tick();
    chk("xor_valid", out_valid, 1);
    chk("xor_zero", out_zero, 1);
    chk("xor_carry", out_carryout, 0);
    chk("xor_ovf", out_overflow, 0);
    chk("xor_tag", out_tag, 2);
    tick();
    // fill with output blocked
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(i + 16);
      in_b     = 32'(i);
      in_cmd   = 3'd0;
      in_tag   = 4'(i);
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    chk("full_pending_tag", out_tag, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("wait_stable_tag", out_tag, 0);
    chk("wait_stable_res", out_result, 16);
    chk("wait_count", count, 4);
    out_ready = 1'b1;
    got = 0;
    for (int w = 0; w < 40 && got < 5; w++) begin
      if (out_valid) begin
        chk("drain_tag", out_tag, 64'(got));
        chk("drain_res", out_result, 64'(2 * got + 16));
        got++;
      end
      tick();
    end
    chk("drain_got", got, 5);
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      tick();
    end
    chk("drain_extra", extra, 0);
    chk("drain_count", count, 0);
    // back-to-back spacing and head stability
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 32'h100 * 32'(i + 1);
      in_b     = 32'd1;
      in_cmd   = 3'd4;
      in_tag   = 4'(7 + i);
      tick();
    end
    in_valid = 1'b0;
    t0 = -1; t1 = -1; t2 = -1; seen = 0;
    for (int c = 0; c < 16; c++) begin
      ahist[c] = alu_operandA;
      if (out_valid) begin
        if (seen == 0) t0 = c; else if (seen == 1) t1 = c; else t2 = c;
        seen++;
      end
      tick();
    end
    chk("b2b_seen", seen, 3);
    chk("b2b_first", t0, 1);
    chk("b2b_gap1", t1 - t0, 3);
    chk("b2b_gap2", t2 - t1, 3);
    chk("b2b_hold0", ahist[1], 32'h200);
    chk("b2b_hold1", ahist[2], 32'h200);
    chk("b2b_hold2", ahist[3], 32'h200);
    chk("b2b_next", ahist[4], 32'h300);
    // flush with pending output
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(100 + i);
      in_b     = 32'd0;
      in_cmd   = 3'd7;
      in_tag   = 4'(10 + i);
      tick();
    end
    chk("prefl_count", count, 4);
    flush  = 1'b1;
    in_tag = 4'd15;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid_kept", out_valid, 1);
    chk("fl_tag_kept", out_tag, 10);
    chk("fl_alu_a", alu_operandA, 0);
    out_ready = 1'b1;
    tick();
    chk("fl_delivered", out_valid, 0);
    extra = 0;
    repeat (8) begin
      if (out_valid) extra++;
      tick();
    end
    chk("fl_no_more", extra, 0);
    // async reset mid-settle
    out_ready = 1'b0;
    push(32'h1234_5678, 32'd0, 3'd0, 4'd6);
    repeat (3) tick();
    chk("pre_rst_valid", out_valid, 1);
    push(32'd1, 32'd1, 3'd0, 4'd7);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_tag", out_tag, 0);
    chk("arst_count", count, 0);
    chk("arst_alu_a", alu_operandA, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
